// File: rtl/req_arbiter4_if.sv
// req_arbiter4_if: request/grant bundle between four requesters and the
// shared-resource arbiter.
//   req     [3:0] level-sensitive request lines, one per requester
//   done          owner signals transfer complete
//   gnt     [3:0] one-hot grant
//   gnt_id  [1:0] encoded index of the granted requester
//   gnt_v         grant valid (equals |gnt)
//   timeout       one-cycle pulse on a forced (hold-limit) release
// Modports: master = requester side, slave = arbiter side.
interface req_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_v;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_v, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_v, timeout
  );
endinterface

// File: rtl/req_arbiter4.sv
// req_arbiter4: four-requester arbiter for one shared downstream resource.
// A winner is picked in IDLE (fixed priority or round-robin) and holds the
// grant until done, until it drops its request, or until MAX_HOLD cycles
// have elapsed. Every release passes through one IDLE cycle.
// Parameters:
//   RR       1 = round-robin, 0 = fixed priority (req[3] highest)
//   MAX_HOLD maximum grant length in cycles (1..255)
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  req_arbiter4_if.slave (req, done in; gnt, gnt_id, gnt_v, timeout out)
module req_arbiter4 #(
  parameter int RR       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  req_arbiter4_if.slave     bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] HOLD = 8'(MAX_HOLD);

  logic [0:0] state;
  logic [1:0] last;
  logic [7:0] cnt;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  logic rel_done;
  logic rel_drop;
  logic rel_max;
  logic release_now;

  // Winner selection. Fixed priority: ascending scan so the highest set
  // index is the one left in win. Round-robin: scan last+1 .. last+4
  // (mod 4) and keep the first hit.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (RR == 0) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.req[i]) win = 2'(i);
      end
    end else begin
      for (int unsigned i = 1; i <= 4; i++) begin
        idx = last + 2'(i);
        if (!found && bus.req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rel_done    = bus.done;
    rel_drop    = !bus.req[bus.gnt_id];
    rel_max     = (cnt == HOLD);
    release_now = rel_done || rel_drop || rel_max;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last        <= 2'd3;
      cnt         <= '0;
      bus.gnt     <= '0;
      bus.gnt_id  <= '0;
      bus.gnt_v   <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      if (state == IDLE) begin
        if (|bus.req) begin
          state      <= GRANT;
          bus.gnt    <= 4'b0001 << win;
          bus.gnt_id <= win;
          bus.gnt_v  <= 1'b1;
          cnt        <= 8'd1;
        end
      end else begin
        if (release_now) begin
          state       <= IDLE;
          bus.gnt     <= '0;
          bus.gnt_id  <= '0;
          bus.gnt_v   <= 1'b0;
          last        <= bus.gnt_id;
          cnt         <= '0;
          // A hold-limit release coinciding with done or a dropped request
          // is treated as a normal release.
          bus.timeout <= rel_max && !rel_done && !rel_drop;
        end else if (cnt != HOLD) begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_req_arbiter4.sv
module tb_req_arbiter4;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  req_arbiter4_if if_fp ();
  req_arbiter4_if if_rr ();

  req_arbiter4 #(.RR(0), .MAX_HOLD(8)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (if_fp.slave)
  );

  req_arbiter4 #(.RR(1), .MAX_HOLD(3)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (if_rr.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] id,
                                    input logic v, input logic t);
    return {g, id, v, t};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b ({gnt,gnt_id,gnt_v,timeout})", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs_fp();
    return {if_fp.gnt, if_fp.gnt_id, if_fp.gnt_v, if_fp.timeout};
  endfunction

  function automatic logic [7:0] obs_rr();
    return {if_rr.gnt, if_rr.gnt_id, if_rr.gnt_v, if_rr.timeout};
  endfunction

  initial begin
    int ids [5];
    ids = '{0, 1, 2, 3, 0};
    n_assert = 0;
    n_fail   = 0;

    // Reset with all requests high
    rst = 1'b1;
    if_fp.req = 4'b1111; if_fp.done = 1'b0;
    if_rr.req = 4'b1111; if_rr.done = 1'b0;
    tick(); tick();
    chk("reset_fp", obs_fp(), 8'h00);
    chk("reset_rr", obs_rr(), 8'h00);

    // Release reset with no requests: stay idle
    rst = 1'b0;
    if_fp.req = 4'b0000;
    if_rr.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_fp", obs_fp(), 8'h00);
      chk("idle_rr", obs_rr(), 8'h00);
    end

    // Fixed priority: 0110 -> requester 2, done held high
    if_fp.req = 4'b0110; if_fp.done = 1'b1;
    tick(); chk("fp_grant2_a", obs_fp(), pk(4'b0100, 2'd2, 1'b1, 1'b0));
    tick(); chk("fp_dead_a",   obs_fp(), 8'h00);
    tick(); chk("fp_grant2_b", obs_fp(), pk(4'b0100, 2'd2, 1'b1, 1'b0));
    if_fp.req = 4'b0011;
    tick(); chk("fp_dead_b",   obs_fp(), 8'h00);
    tick(); chk("fp_grant1_a", obs_fp(), pk(4'b0010, 2'd1, 1'b1, 1'b0));
    tick(); chk("fp_dead_c",   obs_fp(), 8'h00);
    tick(); chk("fp_grant1_b", obs_fp(), pk(4'b0010, 2'd1, 1'b1, 1'b0));
    if_fp.req = 4'b0000; if_fp.done = 1'b0;
    tick(); chk("fp_release",  obs_fp(), 8'h00);
    chk("rr_quiet", obs_rr(), 8'h00);

    // Round-robin: 1111 with done -> 0,1,2,3,0 separated by dead cycles
    if_rr.req = 4'b1111; if_rr.done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rr_grant_%0d", k), obs_rr(),
          pk(4'b0001 << ids[k], 2'(ids[k]), 1'b1, 1'b0));
      tick();
      chk($sformatf("rr_dead_%0d", k), obs_rr(), 8'h00);
    end
    if_rr.req = 4'b0000; if_rr.done = 1'b0;
    tick(); chk("rr_idle", obs_rr(), 8'h00);

    // Timeout: MAX_HOLD=3, req 0001, done low (last = 0)
    if_rr.req = 4'b0001;
    tick(); chk("to_hold1", obs_rr(), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    tick(); chk("to_hold2", obs_rr(), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    tick(); chk("to_hold3", obs_rr(), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    tick(); chk("to_pulse", obs_rr(), pk(4'b0000, 2'd0, 1'b0, 1'b1));
    tick(); chk("to_regrant", obs_rr(), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    if_rr.req = 4'b0000;
    tick(); chk("to_drop", obs_rr(), 8'h00);

    // done coincident with hold limit: normal release, no timeout
    if_rr.req = 4'b0001;
    tick(); tick(); tick();
    chk("col_hold3", obs_rr(), pk(4'b0001, 2'd0, 1'b1, 1'b0));
    if_rr.done = 1'b1;
    tick(); chk("col_no_timeout", obs_rr(), 8'h00);
    if_rr.done = 1'b0; if_rr.req = 4'b0000;
    tick(); chk("col_idle", obs_rr(), 8'h00);

    // Request drop: requester 2 granted (last = 0), drop in grant cycle 2
    if_rr.req = 4'b0100;
    tick(); chk("drop_grant2", obs_rr(), pk(4'b0100, 2'd2, 1'b1, 1'b0));
    if_rr.req = 4'b1110;
    tick(); chk("drop_hold", obs_rr(), pk(4'b0100, 2'd2, 1'b1, 1'b0));
    if_rr.req = 4'b1010;
    tick(); chk("drop_release", obs_rr(), 8'h00);
    tick(); chk("drop_next3", obs_rr(), pk(4'b1000, 2'd3, 1'b1, 1'b0));

    // Asynchronous reset mid-grant
    if_rr.req = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("arst_rr", obs_rr(), 8'h00);
    chk("arst_fp", obs_fp(), 8'h00);
    rst = 1'b0;
    tick(); chk("arst_first0", obs_rr(), pk(4'b0001, 2'd0, 1'b1, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/req_arbiter4.md
# req_arbiter4

Four-requester arbiter that shares one downstream resource, typically a datapath fed through the team's 4-to-2 priority encoder, among four request lines. It picks one requester and holds the grant until the requester signals completion, drops its request, or exceeds a hold limit. It then releases the resource and re-arbitrates. Grant is presented both one-hot and as a 2-bit encoded index with a valid flag, so it can drive the same decode logic the encoder output drives.

## Interface
- RR, default 1: 1 = round-robin arbitration, 0 = fixed priority (req[3] highest, req[0] lowest).
- MAX_HOLD, default 8: maximum grant length in cycles, range 1..255.
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-high.
- req, input, 4: request lines, level-sensitive, one per requester.
- done, input, 1: owner signals its transfer is complete. Sampled only while gnt_v=1.
- gnt, output, 4: one-hot grant, registered.
- gnt_id, output, 2: encoded index of the granted requester, registered.
- gnt_v, output, 1: grant valid, equal to |gnt.
- timeout, output, 1: one-cycle pulse on a forced release.

## Operation
- Two states: IDLE and GRANT. Reset state is IDLE.
- All outputs reset to 0. The internal last-owner pointer `last` resets to 3, so the first round-robin search order is 0,1,2,3. The hold counter `cnt` resets to 0.
- IDLE:
  - If req == 0, stay in IDLE and keep outputs at 0.
  - Otherwise select a winner W and go to GRANT. Set gnt = 1<<W, gnt_id = W, gnt_v = 1, cnt = 1.
- Winner selection:
  - RR=0: highest set index.
  - RR=1: first set bit scanning last+1, last+2, … modulo 4.
- GRANT, evaluated every cycle. A release condition is any one of:
  - (a) done = 1;
  - (b) req[gnt_id] = 0;
  - (c) cnt == MAX_HOLD.
- On release:
  - Go to IDLE and clear gnt, gnt_id and gnt_v on the next edge.
  - Set last = gnt_id.
  - Reset cnt to 0.
- timeout = 1 for exactly one cycle, coincident with the first IDLE cycle, only when (c) is true and neither (a) nor (b) is true.
- Without release, stay in GRANT with gnt unchanged and cnt incremented. cnt is 8 bits and saturates at MAX_HOLD.
- Requests from non-owners arriving during GRANT are ignored until the next IDLE.
- The fixed-priority mode never updates fairness. `last` is still written but not used.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives gnt_v = 1 after edge N (visible in cycle N+1).
- Grant length: at most MAX_HOLD cycles of gnt_v = 1.
- Dead cycle: there is always exactly one IDLE cycle with gnt_v = 0 between consecutive grants. Back-to-back ownership by two requesters is therefore separated by one idle cycle.
- done asserted in the first GRANT cycle gives a 1-cycle grant.
- If done and the timeout condition occur in the same cycle, the release counts as normal: timeout stays 0.
- Asynchronous rst mid-grant forces all outputs to 0 immediately, state to IDLE and last to 3. Arbitration resumes on the first edge after rst deasserts.
- req changes between edges have no effect; only sampled values count.

## Test plan
- **Reset and idle.** Assert rst with req = 4'b1111, then release rst with req = 0 → gnt = 0, gnt_id = 0, gnt_v = 0, timeout = 0 in all cycles.
- **Fixed priority (RR=0).** Hold req = 4'b0110 with done pulsed each grant → every grant goes to requester 2 (gnt = 4'b0100, gnt_id = 2). Change req to 4'b0011 → grants go to requester 1.
- **Round-robin (RR=1).** Hold req = 4'b1111 with done = 1 in each grant cycle → gnt_id sequence 0,1,2,3,0 with a gnt_v = 0 cycle between each grant.
- **Timeout (MAX_HOLD=3).** Hold req = 4'b0001 with done = 0 → gnt_v high for exactly 3 cycles. timeout pulses for 1 cycle, then requester 0 is regranted after the dead cycle.
- **Request drop.** Requester 2 is granted. Drop req[2] in grant cycle 2 with req[1] still high → release, then the next grant goes to gnt_id = 3 if req[3] is high, otherwise to 1 (RR=1). timeout stays 0.
- **Asynchronous reset mid-grant.** Assert rst while gnt = 4'b1000 → outputs go to 0 before the next clock edge. After rst is released with req = 4'b1111 and RR=1, the first grant goes to gnt_id = 0.
